contador_modulo_param: RTL and testbench
========================================

CONTADOR_MODULO_PARAM -- requirements
Module: contador_modulo_param

Interface
REQ-001 Parameter WIDTH, default 3: width of the count state and of load_value.
REQ-002 Parameter MODULUS, default 6: number of count states, range 0 to MODULUS-1; legal values are 2 to 2**WIDTH.
REQ-003 Parameter RESET_VALUE, default 5: count value forced by reset; SHALL be less than MODULUS.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  advance count by one step per clock when high.
REQ-007 up_down  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 one_shot  input  1  mode: 1 = stop at terminal value, 0 = wrap continuously.
REQ-009 clear  input  1  synchronous load of 0.
REQ-010 load  input  1  synchronous load of load_value.
REQ-011 load_value  input  WIDTH  value applied on load.
REQ-012 count  output  WIDTH  registered current count.
REQ-013 terminal_count  output  1  high when count equals the terminal value for the current up_down setting.
REQ-014 wrap_pulse  output  1  registered one-cycle pulse marking a wrap-around.
REQ-015 done  output  1  registered flag showing that a one-shot run has stopped at the terminal value.
REQ-016 load_error  output  1  registered one-cycle pulse marking an out-of-range load.

Function
REQ-017 Terminal value SHALL be MODULUS-1 when up_down=1 and 0 when up_down=0.
REQ-018 terminal_count SHALL be combinational from count and up_down only, with no added latency.
REQ-019 Per-edge priority SHALL be clear > load > enable > hold.
REQ-020 clear=1: count SHALL become 0 and done SHALL become 0 on that edge, regardless of load and enable.
REQ-021 load=1 with clear=0 and load_value < MODULUS: count SHALL become load_value, done SHALL become 0, and load_error SHALL be 0.
REQ-022 load=1 with clear=0 and load_value >= MODULUS: count SHALL become 0, done SHALL become 0, and load_error SHALL pulse high for exactly one cycle.
REQ-023 enable=1 with no clear or load, count not at terminal, and done=0: count SHALL step by +1 (up) or -1 (down) on that edge.
REQ-024 enable=1, count at terminal, one_shot=0: count SHALL wrap (MODULUS-1 to 0 up, 0 to MODULUS-1 down), and wrap_pulse SHALL be high in the cycle the wrapped value appears.
REQ-025 enable=1, count at terminal, one_shot=1: count SHALL hold, done SHALL set to 1, and wrap_pulse SHALL stay 0.
REQ-026 done=1 SHALL freeze count against enable until clear, load or reset occurs; a change of up_down alone SHALL NOT clear done.
REQ-027 enable=0 with no clear or load: count, done SHALL hold, and wrap_pulse, load_error SHALL be 0.
REQ-028 Changing up_down mid-count SHALL take effect on the next enabled edge, with no skipped or repeated value.
REQ-029 wrap_pulse and load_error SHALL be high for at most one cycle per triggering event; consecutive wraps SHALL give one pulse each.
REQ-030 count SHALL never hold a value >= MODULUS.
REQ-031 Arithmetic SHALL be modulo MODULUS on WIDTH bits, with no overflow into unused codes when MODULUS < 2**WIDTH.

Reset
REQ-032 reset=1 SHALL immediately, independent of clock, set count=RESET_VALUE, done=0, wrap_pulse=0 and load_error=0.
REQ-033 While reset=1, all inputs SHALL be ignored; the first enabled edge after deassertion SHALL step from RESET_VALUE.
REQ-034 reset asserted mid-run or mid-pulse SHALL abort the run and the pulse with no residual effect.

Verification
REQ-035 Defaults, reset then enable=1, up_down=1, one_shot=0 for 8 clocks -> count 5,0,1,2,3,4,5,0; wrap_pulse high only when count shows 0.
REQ-036 up_down=0 from count=1, enable for 3 clocks -> count 0,5,4; terminal_count high at 0; wrap_pulse high with 5.
REQ-037 one_shot=1, load 3, up count -> 4,5,5,5; done=1 from the cycle after 5 is reached; load_value=2 then load=1 -> count=2, done=0.
REQ-038 load=1, load_value=7 -> count=0, load_error high for 1 cycle; clear=1 and load=1 together with load_value=4 -> count=0.
REQ-039 Assert reset asynchronously mid-count at count=3 -> count=5 before the next clock edge, and all pulses 0.
REQ-040 Parameter override WIDTH=4, MODULUS=10, RESET_VALUE=0, counting up 12 clocks -> 0..9,0,1 with one wrap_pulse, and count never above 9.

Source files
------------

// File: rtl/contador_modulo_param.sv
// Parameterised modulo-N up/down counter with clear/load, one-shot stop and wrap/load-error pulses.
// Terminal flag is combinational from count and direction; every other output is registered.
module contador_modulo_param #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned MODULUS     = 6,
  parameter int unsigned RESET_VALUE = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             one_shot,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             terminal_count,
  output logic             wrap_pulse,
  output logic             done,
  output logic             load_error
);

  // One extra bit so MODULUS == 2**WIDTH is still representable in the range check.
  localparam int unsigned     EXT_W   = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             lerr_q, lerr_d;

  logic             at_term;
  logic             load_ok;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;

  // Terminal detection and modulo neighbours of the current count.
  always_comb begin
    at_term = up_down ? (count_q == MAX_VAL) : (count_q == '0);
    load_ok = {1'b0, load_value} < MOD_EXT;
    inc_val = (count_q == MAX_VAL) ? '0 : count_q + WIDTH'(1);
    dec_val = (count_q == '0) ? MAX_VAL : count_q - WIDTH'(1);
  end

  // Next state: clear > load > enable > hold.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    if (clear) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (load) begin
      done_d = 1'b0;
      if (load_ok) begin
        count_d = load_value;
      end else begin
        count_d = '0;
        lerr_d  = 1'b1;
      end
    end else if (enable && !done_q) begin
      if (at_term && one_shot) begin
        done_d = 1'b1;
      end else begin
        count_d = up_down ? inc_val : dec_val;
        wrap_d  = at_term;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= RST_VAL;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign count          = count_q;
  assign terminal_count = at_term;
  assign wrap_pulse     = wrap_q;
  assign done           = done_q;
  assign load_error     = lerr_q;

endmodule

// File: tb/tb_contador_modulo_param.sv
// Self-checking bench: default and (4,10,0) counters driven together, checked each cycle
// against an arithmetic model, plus literal expectations for the directed scenarios.
module tb_contador_modulo_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b1;
  logic       one_shot = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [2:0] lv1 = '0;
  logic [3:0] lv2 = '0;

  logic [2:0] count1;
  logic [3:0] count2;
  logic       tc1, tc2, wrap1, wrap2, done1, done2, lerr1, lerr2;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  // model state, index 0 = default instance, 1 = overridden instance
  int m_cnt  [2];
  int m_done [2];
  int m_wrap [2];
  int m_lerr [2];
  int modulus [2] = '{6, 10};
  int rstval  [2] = '{5, 0};

  always #5 clock = ~clock;

  contador_modulo_param dut1 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .one_shot(one_shot), .clear(clear), .load(load), .load_value(lv1),
    .count(count1), .terminal_count(tc1), .wrap_pulse(wrap1), .done(done1),
    .load_error(lerr1)
  );

  contador_modulo_param #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .one_shot(one_shot), .clear(clear), .load(load), .load_value(lv2),
    .count(count2), .terminal_count(tc2), .wrap_pulse(wrap2), .done(done2),
    .load_error(lerr2)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: modulo arithmetic with the clear/load/enable priority rules.
  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      int m, lv, term;
      m  = modulus[i];
      lv = (i == 0) ? int'(lv1) : int'(lv2);
      term = up_down ? m - 1 : 0;
      if (reset) begin
        m_cnt[i] <= rstval[i]; m_done[i] <= 0; m_wrap[i] <= 0; m_lerr[i] <= 0;
      end else if (clear) begin
        m_cnt[i] <= 0; m_done[i] <= 0; m_wrap[i] <= 0; m_lerr[i] <= 0;
      end else if (load) begin
        m_cnt[i]  <= (lv < m) ? lv : 0;
        m_lerr[i] <= (lv < m) ? 0 : 1;
        m_done[i] <= 0; m_wrap[i] <= 0;
      end else if (enable && m_done[i] == 0) begin
        m_lerr[i] <= 0;
        if (m_cnt[i] == term && one_shot) begin
          m_done[i] <= 1; m_wrap[i] <= 0;
        end else begin
          m_cnt[i]  <= (m_cnt[i] + (up_down ? 1 : m - 1)) % m;
          m_wrap[i] <= (m_cnt[i] == term) ? 1 : 0;
        end
      end else begin
        m_wrap[i] <= 0; m_lerr[i] <= 0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (checking) begin
      int exp_tc1, exp_tc2;
      exp_tc1 = up_down ? int'(m_cnt[0] == 5) : int'(m_cnt[0] == 0);
      exp_tc2 = up_down ? int'(m_cnt[1] == 9) : int'(m_cnt[1] == 0);
      chk("m1_count", int'(count1), m_cnt[0]);
      chk("m1_tc",    int'(tc1),    exp_tc1);
      chk("m1_wrap",  int'(wrap1),  m_wrap[0]);
      chk("m1_done",  int'(done1),  m_done[0]);
      chk("m1_lerr",  int'(lerr1),  m_lerr[0]);
      chk("m1_range", int'(count1 < 3'd6), 1);
      chk("m2_count", int'(count2), m_cnt[1]);
      chk("m2_tc",    int'(tc2),    exp_tc2);
      chk("m2_wrap",  int'(wrap2),  m_wrap[1]);
      chk("m2_done",  int'(done2),  m_done[1]);
      chk("m2_lerr",  int'(lerr2),  m_lerr[1]);
      chk("m2_range", int'(count2 < 4'd10), 1);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  int exp1 [11] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4};
  int exp2 [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};

  initial begin
    #1 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checking = 1'b1;

    // reset state
    chk("rst_count1", int'(count1), 5);
    chk("rst_tc1",    int'(tc1), 1);
    chk("rst_done1",  int'(done1), 0);
    chk("rst_wrap1",  int'(wrap1), 0);
    chk("rst_lerr1",  int'(lerr1), 0);
    chk("rst_count2", int'(count2), 0);
    chk("rst_tc2",    int'(tc2), 0);

    // free-running up count on both instances
    enable = 1'b1; up_down = 1'b1; one_shot = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tick();
      chk("up_count1", int'(count1), exp1[k]);
      chk("up_wrap1",  int'(wrap1), int'(exp1[k] == 0));
      chk("up_count2", int'(count2), exp2[k]);
      chk("up_wrap2",  int'(wrap2), int'(k == 9));
    end

    // down count through zero
    load = 1'b1; lv1 = 3'd1; lv2 = 4'd3; enable = 1'b0;
    tick();
    chk("ld1_count1", int'(count1), 1);
    load = 1'b0; up_down = 1'b0; enable = 1'b1;
    tick();
    chk("dn_count_a", int'(count1), 0);
    chk("dn_tc_a",    int'(tc1), 1);
    chk("dn_wrap_a",  int'(wrap1), 0);
    tick();
    chk("dn_count_b", int'(count1), 5);
    chk("dn_wrap_b",  int'(wrap1), 1);
    chk("dn_tc_b",    int'(tc1), 0);
    tick();
    chk("dn_count_c", int'(count1), 4);
    chk("dn_wrap_c",  int'(wrap1), 0);

    // one-shot run stops at terminal and freezes
    enable = 1'b0; load = 1'b1; lv1 = 3'd3; one_shot = 1'b1; up_down = 1'b1;
    tick();
    chk("os_load", int'(count1), 3);
    load = 1'b0; enable = 1'b1;
    tick(); chk("os_c4", int'(count1), 4);
    tick(); chk("os_c5", int'(count1), 5); chk("os_done_a", int'(done1), 0);
    tick(); chk("os_c5b", int'(count1), 5); chk("os_done_b", int'(done1), 1);
    chk("os_wrap", int'(wrap1), 0);
    up_down = 1'b0;
    tick(); chk("os_frozen", int'(count1), 5); chk("os_done_c", int'(done1), 1);
    load = 1'b1; lv1 = 3'd2;
    tick(); chk("os_reload", int'(count1), 2); chk("os_done_d", int'(done1), 0);

    // out-of-range load and clear priority
    enable = 1'b0; one_shot = 1'b0; up_down = 1'b1; lv1 = 3'd7; lv2 = 4'd12;
    tick();
    chk("bad_count1", int'(count1), 0); chk("bad_lerr1", int'(lerr1), 1);
    chk("bad_count2", int'(count2), 0); chk("bad_lerr2", int'(lerr2), 1);
    load = 1'b0;
    tick(); chk("bad_lerr_off", int'(lerr1), 0);
    clear = 1'b1; load = 1'b1; lv1 = 3'd4;
    tick(); chk("clr_pri", int'(count1), 0); chk("clr_lerr", int'(lerr1), 0);
    clear = 1'b0; load = 1'b0;

    // asynchronous reset mid-count
    load = 1'b1; lv1 = 3'd3;
    tick();
    load = 1'b0; enable = 1'b1;
    chk("pre_rst", int'(count1), 3);
    reset = 1'b1;
    #1;
    chk("arst_count", int'(count1), 5);
    chk("arst_wrap", int'(wrap1), 0);
    chk("arst_done", int'(done1), 0);
    chk("arst_lerr", int'(lerr1), 0);
    tick(); chk("rst_hold", int'(count1), 5);
    reset = 1'b0;
    tick(); chk("post_rst", int'(count1), 0); chk("post_rst_wrap", int'(wrap1), 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (reset) reset = ($urandom_range(0, 1) == 0);
      else       reset = ($urandom_range(0, 63) == 0);
      clear  = ($urandom_range(0, 15) == 0);
      load   = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)  up_down  = ~up_down;
      if ($urandom_range(0, 31) == 0) one_shot = ~one_shot;
      lv1 = 3'($urandom_range(0, 7));
      lv2 = 4'($urandom_range(0, 15));
      tick();
    end

    reset = 1'b0;
    tick();
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
